// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: states, instruction
// classes, opcode/ext fields, ALU codes, flag positions, condition codes, mux selects.
package ctrl_pkg;
  localparam int WIDTH            = 16;
  localparam int ALU_CONT_BITS    = 6;
  localparam int REG_BITS         = 4;
  localparam int OP_CODE_BITS     = 4;
  localparam int EXT_OP_CODE_BITS = 4;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_LOAD_WB, S_HALT
  } ctrl_state_e;

  typedef enum logic [2:0] {
    C_NOP, C_ALU_R, C_ALU_I, C_LOAD, C_STOR, C_JAL, C_JCOND, C_BCOND
  } instr_class_e;

  localparam logic [OP_CODE_BITS-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OP_CODE_BITS-1:0] OP_MEM   = 4'b0100;
  localparam logic [OP_CODE_BITS-1:0] OP_BCOND = 4'b1100;

  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_WAIT  = 4'b0000;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_AND   = 4'b0001;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_OR    = 4'b0010;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_XOR   = 4'b0011;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_ADD   = 4'b0101;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_SUB   = 4'b1001;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_CMP   = 4'b1011;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_MOV   = 4'b1101;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_LOAD  = 4'b0000;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_STOR  = 4'b0100;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_JAL   = 4'b1000;
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_JCOND = 4'b1100;

  localparam logic [ALU_CONT_BITS-1:0] ALU_ADD = 6'd0;
  localparam logic [ALU_CONT_BITS-1:0] ALU_SUB = 6'd1;
  localparam logic [ALU_CONT_BITS-1:0] ALU_AND = 6'd2;
  localparam logic [ALU_CONT_BITS-1:0] ALU_OR  = 6'd3;
  localparam logic [ALU_CONT_BITS-1:0] ALU_XOR = 6'd4;
  localparam logic [ALU_CONT_BITS-1:0] ALU_CMP = 6'd5;
  localparam logic [ALU_CONT_BITS-1:0] ALU_MOV = 6'd6;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 2;
  localparam int FLAG_F = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_N = 7;

  localparam logic [REG_BITS-1:0] COND_EQ = 4'b0000;
  localparam logic [REG_BITS-1:0] COND_NE = 4'b0001;
  localparam logic [REG_BITS-1:0] COND_CS = 4'b0010;
  localparam logic [REG_BITS-1:0] COND_CC = 4'b0011;
  localparam logic [REG_BITS-1:0] COND_HI = 4'b0100;
  localparam logic [REG_BITS-1:0] COND_LS = 4'b0101;
  localparam logic [REG_BITS-1:0] COND_GT = 4'b0110;
  localparam logic [REG_BITS-1:0] COND_LE = 4'b0111;
  localparam logic [REG_BITS-1:0] COND_UC = 4'b1110;

  localparam logic [1:0] PC_SRC_BRANCH = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
  localparam logic [1:0] PC_SRC_NEXT   = 2'd2;

  localparam logic [1:0] RWS_ALU  = 2'd0;
  localparam logic [1:0] RWS_MEM  = 2'd1;
  localparam logic [1:0] RWS_LINK = 2'd2;

  // Same table serves the R-type ext field and the immediate opcode field.
  // MSB is the "recognised ALU op" flag, the rest is the alu_cont code.
  function automatic logic [ALU_CONT_BITS:0] alu_decode(input logic [3:0] code);
    case (code)
      EXT_AND: return {1'b1, ALU_AND};
      EXT_OR:  return {1'b1, ALU_OR};
      EXT_XOR: return {1'b1, ALU_XOR};
      EXT_ADD: return {1'b1, ALU_ADD};
      EXT_SUB: return {1'b1, ALU_SUB};
      EXT_CMP: return {1'b1, ALU_CMP};
      EXT_MOV: return {1'b1, ALU_MOV};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/controller_if.sv
// Controller <-> datapath bundle: instruction fields and live flags in,
// enables, mux selects and status out.
interface controller_if;
  import ctrl_pkg::*;

  logic [OP_CODE_BITS-1:0]     op_code;
  logic [EXT_OP_CODE_BITS-1:0] ext_op_code;
  logic [REG_BITS-1:0]         A_index;
  logic [WIDTH-1:0]            psr_flags;

  logic                     reg_write;
  logic                     alu_A_src;
  logic                     alu_B_src;
  logic                     pc_en;
  logic                     loading;
  logic                     storing;
  logic [1:0]               pc_src;
  logic [1:0]               reg_write_src;
  logic [ALU_CONT_BITS-1:0] alu_cont;
  logic [WIDTH-1:0]         flags_q;
  logic                     instr_done;
  logic                     halted;

  modport master (
    input  op_code, ext_op_code, A_index, psr_flags,
    output reg_write, alu_A_src, alu_B_src, pc_en, loading, storing,
           pc_src, reg_write_src, alu_cont, flags_q, instr_done, halted
  );

  modport slave (
    output op_code, ext_op_code, A_index, psr_flags,
    input  reg_write, alu_A_src, alu_B_src, pc_en, loading, storing,
           pc_src, reg_write_src, alu_cont, flags_q, instr_done, halted
  );
endinterface

// File: rtl/controller_cond_eval.sv
// Branch/jump condition resolver: decides "taken" from the latched flag register
// and the 4-bit condition code carried in A_index.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [WIDTH-1:0]    flags_q,
  input  logic [REG_BITS-1:0] cond,
  output logic                taken
);
  logic unused_flag_bits;
  assign unused_flag_bits = ^{flags_q[WIDTH-1:8], flags_q[FLAG_F:3], flags_q[1]};

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken =  flags_q[FLAG_Z];
      COND_NE: taken = ~flags_q[FLAG_Z];
      COND_CS: taken =  flags_q[FLAG_C];
      COND_CC: taken = ~flags_q[FLAG_C];
      COND_HI: taken =  flags_q[FLAG_L];
      COND_LS: taken = ~flags_q[FLAG_L];
      COND_GT: taken =  flags_q[FLAG_N];
      COND_LE: taken = ~flags_q[FLAG_N];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/controller.sv
// Multicycle control unit: FETCH -> DECODE -> EXEC (-> LOAD_WB) sequencer with a
// Moore output decode, the architectural flag register and branch resolution.
module controller
  import ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  controller_if.master  bus,
  output ctrl_state_e   state_dbg
);
  ctrl_state_e              state, state_next;
  instr_class_e             cls_q, cls_d;
  logic [ALU_CONT_BITS-1:0] alu_op_q, alu_op_d;
  logic [REG_BITS-1:0]      cond_q;
  logic [WIDTH-1:0]         flags_q;
  logic [ALU_CONT_BITS:0]   ext_dec, op_dec;
  logic                     halt_d, taken, flag_load;

  logic                     reg_write, alu_A_src, alu_B_src, pc_en, loading, storing, halted;
  logic [1:0]               pc_src, reg_write_src;
  logic [ALU_CONT_BITS-1:0] alu_cont;

  assign ext_dec = alu_decode(bus.ext_op_code);
  assign op_dec  = alu_decode(bus.op_code);

  // Instruction classification, sampled into cls_q at the end of DECODE.
  always_comb begin
    cls_d    = C_NOP;
    alu_op_d = ALU_ADD;
    halt_d   = 1'b0;
    if (bus.op_code == OP_RTYPE) begin
      if (bus.ext_op_code == EXT_WAIT) begin
        halt_d = 1'b1;
      end else if (ext_dec[ALU_CONT_BITS]) begin
        cls_d    = C_ALU_R;
        alu_op_d = ext_dec[ALU_CONT_BITS-1:0];
      end
    end else if (op_dec[ALU_CONT_BITS]) begin
      cls_d    = C_ALU_I;
      alu_op_d = op_dec[ALU_CONT_BITS-1:0];
    end else if (bus.op_code == OP_MEM) begin
      case (bus.ext_op_code)
        EXT_LOAD:  cls_d = C_LOAD;
        EXT_STOR:  cls_d = C_STOR;
        EXT_JAL:   cls_d = C_JAL;
        EXT_JCOND: cls_d = C_JCOND;
        default:   cls_d = C_NOP;
      endcase
    end else if (bus.op_code == OP_BCOND) begin
      cls_d = C_BCOND;
    end
  end

  cond_eval u_cond_eval (
    .flags_q (flags_q),
    .cond    (cond_q),
    .taken   (taken)
  );

  assign flag_load = (state == S_EXEC) && (cls_q == C_ALU_R || cls_q == C_ALU_I) &&
                     (alu_op_q == ALU_ADD || alu_op_q == ALU_SUB || alu_op_q == ALU_CMP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_q    <= C_NOP;
      alu_op_q <= ALU_ADD;
      cond_q   <= '0;
      flags_q  <= '0;
    end else begin
      if (state == S_DECODE) begin
        cls_q    <= cls_d;
        alu_op_q <= alu_op_d;
        cond_q   <= bus.A_index;
      end
      if (flag_load) flags_q <= bus.psr_flags;
    end
  end

  // Outputs depend only on registered state, so reset idles them immediately.
  always_comb begin
    state_next    = state;
    reg_write     = 1'b0;
    alu_A_src     = 1'b0;
    alu_B_src     = 1'b0;
    pc_en         = 1'b0;
    loading       = 1'b0;
    storing       = 1'b0;
    halted        = 1'b0;
    pc_src        = PC_SRC_NEXT;
    reg_write_src = RWS_ALU;
    alu_cont      = ALU_ADD;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = halt_d ? S_HALT : S_EXEC;
      S_EXEC: begin
        state_next = S_FETCH;
        pc_en      = 1'b1;
        case (cls_q)
          C_ALU_R, C_ALU_I: begin
            alu_A_src = 1'b1;
            alu_B_src = (cls_q == C_ALU_I);
            alu_cont  = alu_op_q;
            reg_write = (alu_op_q != ALU_CMP);
          end
          C_LOAD: begin
            loading    = 1'b1;
            pc_en      = 1'b0;
            state_next = S_LOAD_WB;
          end
          C_STOR: storing = 1'b1;
          C_JAL: begin
            reg_write     = 1'b1;
            reg_write_src = RWS_LINK;
            pc_src        = PC_SRC_JUMP;
          end
          C_JCOND: pc_src = taken ? PC_SRC_JUMP : PC_SRC_NEXT;
          C_BCOND: begin
            alu_B_src = 1'b1;
            alu_cont  = ALU_ADD;
            pc_src    = taken ? PC_SRC_BRANCH : PC_SRC_NEXT;
          end
          default: ;
        endcase
      end
      S_LOAD_WB: begin
        state_next    = S_FETCH;
        loading       = 1'b1;
        reg_write     = 1'b1;
        reg_write_src = RWS_MEM;
        pc_en         = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  assign bus.reg_write     = reg_write;
  assign bus.alu_A_src     = alu_A_src;
  assign bus.alu_B_src     = alu_B_src;
  assign bus.pc_en         = pc_en;
  assign bus.loading       = loading;
  assign bus.storing       = storing;
  assign bus.pc_src        = pc_src;
  assign bus.reg_write_src = reg_write_src;
  assign bus.alu_cont      = alu_cont;
  assign bus.flags_q       = flags_q;
  assign bus.instr_done    = pc_en;
  assign bus.halted        = halted;
  assign state_dbg         = state;
endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the controller: a driver issues instructions and pushes the
// reference model's per-instruction summary; a monitor compares at every retire.
module tb_controller;
  import ctrl_pkg::*;

  localparam int W = 39;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  ctrl_state_e state_dbg;

  controller_if bus();

  controller dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           vectors = 0;
  int           fails   = 0;
  logic [15:0]  flags_m = '0;
  int           cyc = 0, n_pc = 0, n_wr = 0, n_ld = 0, n_st = 0;
  logic [3:0]   alu_codes[7] = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-instruction summary: latency, selects at retire, and how many cycles each
  // one-shot control was high during the instruction, plus the flag register seen.
  function automatic logic [W-1:0] pack(input int lat, input logic [1:0] ps, input int npc,
                                        input int nwr, input logic [1:0] rws, input logic [5:0] ac,
                                        input logic as, input logic bs, input int nld, input int nst,
                                        input logic [15:0] fl);
    return {lat[2:0], ps, npc[1:0], nwr[1:0], rws, ac, as, bs, nld[1:0], nst[1:0], fl};
  endfunction

  function automatic logic [W-1:0] out_vec();
    return W'({state_dbg, bus.reg_write, bus.alu_A_src, bus.alu_B_src, bus.pc_en,
               bus.loading, bus.storing, bus.instr_done, bus.halted,
               bus.pc_src, bus.reg_write_src, bus.alu_cont, bus.flags_q});
  endfunction

  function automatic logic [W-1:0] idle_vec();
    return W'({S_FETCH, 8'b0, 2'd2, 2'd0, 6'd0, 16'd0});
  endfunction

  function automatic int ref_alu(input logic [3:0] c);
    case (c)
      4'b0001: return 2;
      4'b0010: return 3;
      4'b0011: return 4;
      4'b0101: return 0;
      4'b1001: return 1;
      4'b1011: return 5;
      4'b1101: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [3:0] cc, input logic [15:0] f);
    case (cc)
      4'b0000: return f[6];
      4'b0001: return !f[6];
      4'b0010: return f[0];
      4'b0011: return !f[0];
      4'b0100: return f[2];
      4'b0101: return !f[2];
      4'b0110: return f[7];
      4'b0111: return !f[7];
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input logic [3:0] op, input logic [3:0] ext, input logic [3:0] a,
                       input logic [15:0] psr);
    int         lat = 3, nwr = 0, nld = 0, nst = 0, code = -1;
    logic [1:0] ps = 2'd2, rws = 2'd0;
    logic [5:0] ac = 6'd0;
    logic       as = 1'b0, bs = 1'b0;
    if (op == 4'd0 && ref_alu(ext) >= 0) begin
      code = ref_alu(ext);
    end else if (ref_alu(op) >= 0) begin
      code = ref_alu(op);
      bs   = 1'b1;
    end else if (op == 4'd4 && ext == 4'd0) begin
      lat = 4; nwr = 1; rws = 2'd1; nld = 2;
    end else if (op == 4'd4 && ext == 4'd4) begin
      nst = 1;
    end else if (op == 4'd4 && ext == 4'd8) begin
      nwr = 1; rws = 2'd2; ps = 2'd1;
    end else if (op == 4'd4 && ext == 4'd12) begin
      ps = ref_taken(a, flags_m) ? 2'd1 : 2'd2;
    end else if (op == 4'd12) begin
      bs = 1'b1;
      ps = ref_taken(a, flags_m) ? 2'd0 : 2'd2;
    end
    if (code >= 0) begin
      as  = 1'b1;
      ac  = code[5:0];
      nwr = (code == 5) ? 0 : 1;
    end
    exp_q.push_back(pack(lat, ps, 1, nwr, rws, ac, as, bs, nld, nst, flags_m));
    if (code == 0 || code == 1 || code == 5) flags_m = psr;
  endtask

  // Called in the FETCH cycle; returns in the FETCH cycle of the next instruction.
  task automatic issue(input logic [3:0] op, input logic [3:0] ext, input logic [3:0] a,
                       input logic [15:0] psr);
    bit got = 1'b0;
    model(op, ext, a, psr);
    bus.op_code     = op;
    bus.ext_op_code = ext;
    bus.A_index     = a;
    bus.psr_flags   = psr;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      got = bus.instr_done;
    end
    if (!got) check("retire_timeout", W'(0), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_state", out_vec(), idle_vec());
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b1;
    flags_m = '0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cyc = 0; n_pc = 0; n_wr = 0; n_ld = 0; n_st = 0;
    end else begin
      cyc++;
      n_pc += int'(bus.pc_en);
      n_wr += int'(bus.reg_write);
      n_ld += int'(bus.loading);
      n_st += int'(bus.storing);
      if (bus.instr_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", W'(1), W'(0));
        end else begin
          check("retire", pack(cyc, bus.pc_src, n_pc, n_wr, bus.reg_write_src, bus.alu_cont,
                               bus.alu_A_src, bus.alu_B_src, n_ld, n_st, bus.flags_q),
                exp_q.pop_front());
        end
        cyc = 0; n_pc = 0; n_wr = 0; n_ld = 0; n_st = 0;
      end
    end
  end

  initial begin
    logic [3:0]  op, ext, a;
    logic [15:0] psr;
    bit          seen;
    int          n;

    bus.op_code = '0; bus.ext_op_code = '0; bus.A_index = '0; bus.psr_flags = '0;
    do_reset();

    issue(4'b0000, 4'b0101, 4'd3, 16'h00C5);   // ADD
    issue(4'b0100, 4'b0000, 4'd2, 16'h1234);   // LOAD
    issue(4'b1011, 4'b0000, 4'd1, 16'h0040);   // CMPI, Z set
    issue(4'b1100, 4'b0000, 4'd0, 16'hFFFF);   // BEQ taken
    issue(4'b1011, 4'b0000, 4'd1, 16'h0000);   // CMPI, Z clear
    issue(4'b1100, 4'b0000, 4'd0, 16'h0040);   // BEQ not taken
    issue(4'b1001, 4'b0000, 4'd1, 16'hFFFF);   // SUBI, all flags set
    issue(4'b1100, 4'b0000, 4'hF, 16'h0000);   // code 1111 never taken
    issue(4'b0100, 4'b1100, 4'hF, 16'h0000);
    issue(4'b0100, 4'b1100, 4'hE, 16'h0000);   // Jcond UC
    issue(4'b0100, 4'b1000, 4'd5, 16'h0F0F);   // JAL, flags unchanged
    issue(4'b0100, 4'b0100, 4'd5, 16'h0001);   // STOR
    issue(4'b0000, 4'b0111, 4'd5, 16'h0001);   // illegal R-type -> NOP

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 7))
        0: begin op = 4'd0; ext = alu_codes[$urandom_range(0, 6)]; end
        1: begin op = alu_codes[$urandom_range(0, 6)]; ext = 4'($urandom); end
        2: begin op = 4'd4; ext = 4'd0; end
        3: begin op = 4'd4; ext = 4'd4; end
        4: begin op = 4'd4; ext = 4'd8; end
        5: begin op = 4'd4; ext = 4'd12; end
        6: begin op = 4'd12; ext = 4'($urandom); end
        default: begin
          op  = 4'($urandom);
          ext = 4'($urandom);
          if (op == 4'd0 && ext == 4'd0) ext = 4'd7;
        end
      endcase
      a   = 4'($urandom);
      psr = 16'($urandom);
      issue(op, ext, a, psr);
    end

    // WAIT: halts, no retirement, recovers on reset
    bus.op_code = 4'd0; bus.ext_op_code = 4'd0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      seen = bus.halted;
    end
    check("halt_entry", W'(seen), W'(1));
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(bus.pc_en) + int'(!bus.halted);
    end
    check("halt_hold", W'(n), W'(0));
    do_reset();
    issue(4'b0101, 4'b0000, 4'd4, 16'h0080);   // ADDI after halt recovery

    // Reset in LOAD_WB aborts the write at once
    bus.op_code = 4'd4; bus.ext_op_code = 4'd0; bus.A_index = 4'd3; bus.psr_flags = 16'h0044;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = bus.loading && !bus.reg_write;
    end
    check("load_exec_reached", W'(seen), W'(1));
    @(posedge clk);
    #1;
    check("load_wb_write", W'({bus.reg_write, bus.reg_write_src, bus.pc_en}), W'(4'b1011));
    do_reset();
    issue(4'b0000, 4'b1011, 4'd2, 16'h0040);   // CMP after abort
    issue(4'b1100, 4'b0000, 4'd1, 16'h0000);   // BNE sees Z from CMP

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
